// File: rtl/imem_responder.sv
// imem_responder
//
// Instruction-memory responder: the memory end of the IF-stage fetch
// interface. Accepts word fetch requests, returns the instruction word
// LATENCY cycles after acceptance, and flags misaligned or out-of-range
// fetches with imem_err (returning NOP_WORD in that case). A loader write
// port preloads the program store.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   imem_read   fetch request from the IF stage
//   imem_addr   byte fetch address
//   imem_abort  cancel the outstanding fetch (IF flush/redirect)
//   imem_ready  responder can accept a request this cycle
//   imem_valid  one-cycle pulse: imem_data holds the last accepted response
//   imem_data   instruction word (held until the next response)
//   imem_err    qualifies imem_valid: misaligned or out-of-range fetch
//   load_we     loader word write enable
//   load_addr   loader byte address, same mapping as imem_addr
//   load_data   loader write data

module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_read,
  input  logic [31:0] imem_addr,
  input  logic        imem_abort,
  output logic        imem_ready,
  output logic        imem_valid,
  output logic [31:0] imem_data,
  output logic        imem_err,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned, below the base, or past the last stored word. The offset is
  // computed without wrap, so addresses below BASE_ADDR are caught explicitly.
  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) ||
           ((off >> 2) >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IDX_W'(off);
  endfunction

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state;
  logic [3:0]       cnt;
  logic [31:0]      resp_word;
  logic             resp_err;

  logic             fetch_bad;
  logic [IDX_W-1:0] fetch_idx;
  logic [31:0]      fetch_word;
  logic             load_bad;
  logic [IDX_W-1:0] load_idx;
  logic             accept;

  assign fetch_bad  = addr_bad(imem_addr);
  assign fetch_idx  = addr_idx(imem_addr);
  assign load_bad   = addr_bad(load_addr);
  assign load_idx   = addr_idx(load_addr);
  // Error fetches never touch the array, so an out-of-range index is harmless.
  assign fetch_word = fetch_bad ? NOP_WORD : mem[fetch_idx];
  // Abort suppresses any same-cycle accept, including back-to-back in RESP.
  assign accept     = imem_read && imem_ready && !imem_abort;

  // Program store. Not cleared by reset; the read above sees the pre-edge
  // contents, so a same-cycle write to the fetched word returns the old word.
  always_ff @(posedge clk) begin
    if (!reset && load_we && !load_bad) begin
      mem[load_idx] <= load_data;
    end
  end

  // Fetch FSM with registered outputs. The response is captured at the
  // accept edge, so later loader writes cannot leak into an outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      imem_ready <= 1'b1;
      imem_valid <= 1'b0;
      imem_err   <= 1'b0;
      imem_data  <= NOP_WORD;
      resp_word  <= NOP_WORD;
      resp_err   <= 1'b0;
    end else begin
      imem_valid <= 1'b0;
      imem_err   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            resp_word <= fetch_word;
            resp_err  <= fetch_bad;
            if (LATENCY == 1) begin
              state      <= RESP;
              imem_ready <= 1'b1;
              imem_valid <= 1'b1;
              imem_err   <= fetch_bad;
              imem_data  <= fetch_word;
            end else begin
              state      <= BUSY;
              cnt        <= 4'(LATENCY - 1);
              imem_ready <= 1'b0;
            end
          end else begin
            state      <= IDLE;
            imem_ready <= 1'b1;
          end
        end
        BUSY: begin
          // cnt holds the number of BUSY cycles still to go, including this one.
          if (imem_abort) begin
            state      <= IDLE;
            imem_ready <= 1'b1;
          end else if (cnt == 4'd1) begin
            state      <= RESP;
            imem_ready <= 1'b1;
            imem_valid <= 1'b1;
            imem_err   <= resp_err;
            imem_data  <= resp_word;
            cnt        <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          imem_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the IF stage fetch interface (imem_addr / imem_read / imem_data).
- Accepts word fetch requests, returns instruction words after a programmable wait latency, and flags misaligned or out-of-range fetches.
- Provides a loader write port so benches and the top level can preload programs.
- Sits between if_stage and the program store in the core top.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; index = (imem_addr - BASE_ADDR) >> 2
BASE_ADDR, 32'h00000000, byte address of word 0
LATENCY, 1, cycles from request acceptance to imem_valid; legal range 1..15
NOP_WORD, 32'h00000013, word returned on error fetches and driven out of reset

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
imem_read  input  1  fetch request from IF stage
imem_addr  input  32  byte fetch address
imem_abort  input  1  cancel outstanding fetch (IF flush/redirect)
imem_ready  output  1  responder can accept a request this cycle
imem_valid  output  1  imem_data holds the response for the last accepted request (1-cycle pulse)
imem_data  output  32  instruction word
imem_err  output  1  qualifies imem_valid: misaligned or out-of-range fetch
load_we  input  1  loader word write enable
load_addr  input  32  loader byte address, same mapping as imem_addr
load_data  input  32  loader write data

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE, imem_ready=1, imem_valid=0, imem_err=0, imem_data=NOP_WORD, wait counter=0. Array contents are not cleared. Reset dominates abort, load and read in the same cycle.
- States:
  - IDLE: ready=1.
  - BUSY: ready=0; counter counts down.
  - RESP: valid=1, ready=1.
- Accept: imem_read=1 and imem_ready=1 at a clk edge, with imem_abort=0.
  - Address decode and array read happen at the accept edge; the word is held in a response register.
  - Error = addr[1:0]!=0, or addr<BASE_ADDR, or index>=DEPTH_WORDS. On error, response word = NOP_WORD and imem_err is set with imem_valid.
- Latency: imem_valid rises exactly LATENCY cycles after the accept edge.
  - LATENCY=1: IDLE/RESP -> RESP directly.
  - LATENCY>1: -> BUSY with counter=LATENCY-1; decrement each cycle; go to RESP when the counter reaches 1.
- RESP:
  - imem_valid and imem_err are asserted for one cycle.
  - imem_data updates on the edge entering RESP and holds until the next response. It does not return to NOP between fetches.
  - A new accept in RESP is allowed (back-to-back). At LATENCY=1 this gives one response per cycle. With no new request, the next state is IDLE.
- Abort: imem_abort=1 in BUSY -> IDLE next edge, no valid pulse, imem_data unchanged.
  - Abort in RESP suppresses any same-cycle accept. The current valid pulse is already visible and is not retracted.
  - Abort in IDLE has no effect.
- Loader:
  - load_we writes array[index] at the edge, in any state. Error addresses are ignored silently.
  - A write in the same cycle as an accept to the same index: the fetch returns the OLD word.
  - Writes after acceptance are not visible to that outstanding fetch.
- imem_read while imem_ready=0 is ignored. The requester must hold it; no queueing.
- The address is 32-bit unsigned. The index is computed on (addr-BASE_ADDR) with no wrap. Addresses below BASE_ADDR are errors.

Test Plan:
1. Basic fetch: LATENCY=1; preload word0=0x002081B3 and word1=0x06408213; read addr 0 then addr 4 on consecutive cycles -> valid on cycles +1 and +2, data 0x002081B3 then 0x06408213, err=0.
2. Latency: LATENCY=3; fetch addr 8 holding 0x0080A283.
   - ready=0 for 2 cycles after accept.
   - valid exactly 3 cycles after accept with 0x0080A283.
   - A read held high during BUSY is accepted only in RESP.
3. Errors: fetch 0x00000002 -> valid, err=1, data 0x00000013; fetch DEPTH_WORDS*4 (0x400) -> err=1, data NOP; a following fetch of addr 0 -> err=0.
4. Abort: LATENCY=4; accept addr 4, assert imem_abort 2 cycles later -> no valid pulse, ready=1 next cycle, imem_data keeps its prior value; new fetch of addr 0 completes normally.
5. Load/read collision: word1=0xAAAAAAAA; same cycle load_we to addr 4 with 0x55555555 and accept addr 4 -> response 0xAAAAAAAA; a refetch returns 0x55555555.
6. Reset mid-operation: LATENCY=3, reset asserted in BUSY -> next edge: valid=0, ready=1, data=0x00000013; array contents survive (fetch addr 0 returns 0x002081B3).
